// File: rtl/touch_zones.sv
// Touch-strip zone decoder: debounces z, maps the qualified x position onto one of
// N_ZONES equal-width buttons and emits press / long-press / release pulses.
module touch_zones #(
  parameter int N_ZONES   = 3,
  parameter int ZONE_W    = 160,
  parameter int Y_MIN     = 136,
  parameter int START_CNT = 10000000,
  parameter int END_CNT   = 10000000,
  parameter int LONG_CNT  = 50000000,
  parameter int CW        = 32
) (
  input  logic               cclk,
  input  logic               rst,
  input  logic               z,
  input  logic [11:0]        x,
  input  logic [11:0]        y,
  output logic [N_ZONES-1:0] zone_hold,
  output logic [3:0]         zone_idx,
  output logic               press,
  output logic               long_press,
  output logic               release_pulse
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_QUAL = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_RELQ = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      hcnt;
  logic               valid;

  logic [3:0]         zone_sel;
  logic [N_ZONES-1:0] zone_onehot;
  logic               in_range;
  logic               zone_ok;
  logic               qual_hit;
  logic               rel_hit;

  // Zone lookup by range comparison so no divider is needed.
  always_comb begin
    zone_sel    = '0;
    zone_onehot = '0;
    in_range    = 1'b0;
    for (int k = 0; k < N_ZONES; k++) begin
      if (({20'd0, x} >= 32'(k * ZONE_W)) && ({20'd0, x} < 32'((k + 1) * ZONE_W))) begin
        zone_sel       = 4'(k);
        zone_onehot    = '0;
        zone_onehot[k] = 1'b1;
        in_range       = 1'b1;
      end
    end
  end

  assign zone_ok = in_range && ({20'd0, y} > 32'(Y_MIN));

  // Counts are inclusive: the START_CNT-th consecutive high cycle qualifies the
  // press and the END_CNT-th consecutive low cycle qualifies the release.
  assign qual_hit = z && (((state == S_IDLE) && (START_CNT == 1)) ||
                          ((state == S_QUAL) && (cnt == CW'(START_CNT - 1))));
  assign rel_hit  = !z && (((state == S_HELD) && (END_CNT == 1)) ||
                           ((state == S_RELQ) && (cnt == CW'(END_CNT - 1))));

  always_ff @(posedge cclk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      hcnt          <= '0;
      valid         <= 1'b0;
      zone_hold     <= '0;
      zone_idx      <= '0;
      press         <= 1'b0;
      long_press    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      long_press    <= 1'b0;
      release_pulse <= 1'b0;
      if (qual_hit) begin
        state <= S_HELD;
        cnt   <= '0;
        hcnt  <= '0;
        valid <= zone_ok;
        if (zone_ok) begin
          zone_hold <= zone_onehot;
          zone_idx  <= zone_sel;
          press     <= 1'b1;
        end
      end else if (rel_hit) begin
        state         <= S_IDLE;
        cnt           <= '0;
        hcnt          <= '0;
        valid         <= 1'b0;
        zone_hold     <= '0;
        zone_idx      <= '0;
        release_pulse <= valid;
      end else begin
        case (state)
          S_IDLE: begin
            if (z) begin
              state <= S_QUAL;
              cnt   <= CW'(1);
            end
          end
          S_QUAL: begin
            if (!z) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_HELD: begin
            if (z) begin
              // hcnt saturates, so long_press fires only once per touch.
              if (hcnt < CW'(LONG_CNT)) begin
                hcnt       <= hcnt + 1'b1;
                long_press <= valid && (hcnt == CW'(LONG_CNT - 1));
              end
            end else begin
              state <= S_RELQ;
              cnt   <= CW'(1);
            end
          end
          S_RELQ: begin
            if (z) begin
              state <= S_HELD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_touch_zones.sv
// Table-driven scoreboard bench for touch_zones (4 zones of 120, short debounce counts).
module tb_touch_zones;

  localparam int NZ = 4;

  logic          cclk = 1'b0;
  logic          rst;
  logic          z;
  logic [11:0]   x;
  logic [11:0]   y;
  logic [NZ-1:0] zone_hold;
  logic [3:0]    zone_idx;
  logic          press;
  logic          long_press;
  logic          release_pulse;

  typedef struct {
    logic        rst;
    logic        z;
    logic [11:0] x;
    logic [11:0] y;
    logic [3:0]  hold;
    logic [3:0]  idx;
    logic        p;
    logic        l;
    logic        r;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  touch_zones #(
    .N_ZONES(NZ), .ZONE_W(120), .Y_MIN(136),
    .START_CNT(4), .END_CNT(3), .LONG_CNT(10), .CW(16)
  ) dut (
    .cclk(cclk), .rst(rst), .z(z), .x(x), .y(y),
    .zone_hold(zone_hold), .zone_idx(zone_idx),
    .press(press), .long_press(long_press), .release_pulse(release_pulse)
  );

  always #5 cclk = ~cclk;

  function automatic vec_t mk(logic r_, logic z_, int x_, int y_, logic [3:0] h_,
                              int i_, logic p_, logic l_, logic rl_);
    vec_t v;
    v.rst = r_; v.z = z_; v.x = 12'(x_); v.y = 12'(y_);
    v.hold = h_; v.idx = 4'(i_); v.p = p_; v.l = l_; v.r = rl_;
    return v;
  endfunction

  function automatic void add(int n, logic r_, logic z_, int x_, int y_, logic [3:0] h_,
                              int i_, logic p_, logic l_, logic rl_);
    for (int i = 0; i < n; i++) vecs.push_back(mk(r_, z_, x_, y_, h_, i_, p_, l_, rl_));
  endfunction

  task automatic checkOutput();
    vec_t e;
    logic [6:0] act;
    logic [6:0] req;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL scoreboard_empty step %0d", step);
      return;
    end
    e   = exp_q.pop_front();
    act = {zone_hold, press, long_press, release_pulse};
    req = {e.hold, e.p, e.l, e.r};
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL outputs step %0d: got hold=%b press/long/rel=%b%b%b, want hold=%b press/long/rel=%b%b%b",
               step, zone_hold, press, long_press, release_pulse, e.hold, e.p, e.l, e.r);
    end
    if (e.hold != 4'd0 || e.rst) begin
      n_cmp++;
      if (zone_idx !== e.idx) begin
        n_bad++;
        $display("[TB] FAIL zone_idx step %0d: got %0d, want %0d", step, zone_idx, e.idx);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge cclk);
    rst = v.rst; z = v.z; x = v.x; y = v.y;
    exp_q.push_back(v);
    @(posedge cclk);
    #1;
    checkOutput();
    step++;
  endtask

  // Per-zone boundary cases: {x, expected one-hot, expected index}
  int          bx[5]   = '{120, 119, 479, 0, 359};
  logic [3:0]  bh[5]   = '{4'b0010, 4'b0001, 4'b1000, 4'b0001, 4'b0100};
  int          bi[5]   = '{1, 0, 3, 0, 2};

  initial begin
    rst = 1'b1; z = 1'b0; x = '0; y = '0;

    // reset, including reset overriding a high z
    add(2, 1, 0, 0,   0,   4'b0000, 0, 0, 0, 0);
    add(1, 1, 1, 240, 200, 4'b0000, 0, 0, 0, 0);
    // 3-cycle glitch is rejected
    add(3, 0, 1, 240, 200, 4'b0000, 0, 0, 0, 0);
    add(3, 0, 0, 240, 200, 4'b0000, 0, 0, 0, 0);
    // press on 4th high cycle in zone 2
    add(3, 0, 1, 240, 200, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 1, 240, 200, 4'b0100, 2, 1, 0, 0);
    add(3, 0, 1, 240, 200, 4'b0100, 2, 0, 0, 0);
    // 2-cycle gap bridged; moving x/y does not change the latched zone
    add(2, 0, 0, 240, 200, 4'b0100, 2, 0, 0, 0);
    add(1, 0, 1, 0,   0,   4'b0100, 2, 0, 0, 0);
    add(6, 0, 1, 400, 50,  4'b0100, 2, 0, 0, 0);
    add(1, 0, 1, 400, 50,  4'b0100, 2, 0, 1, 0);
    add(3, 0, 1, 400, 50,  4'b0100, 2, 0, 0, 0);
    // release after 3 low cycles
    add(2, 0, 0, 400, 50,  4'b0100, 2, 0, 0, 0);
    add(1, 0, 0, 400, 50,  4'b0000, 0, 0, 0, 1);
    add(2, 0, 0, 400, 50,  4'b0000, 0, 0, 0, 0);
    // out of strip: x past last zone, then y on the boundary
    add(16, 0, 1, 480, 200, 4'b0000, 0, 0, 0, 0);
    add(4,  0, 0, 480, 200, 4'b0000, 0, 0, 0, 0);
    add(16, 0, 1, 10,  136, 4'b0000, 0, 0, 0, 0);
    add(4,  0, 0, 10,  136, 4'b0000, 0, 0, 0, 0);
    // zone edges with y just inside the strip
    for (int i = 0; i < 5; i++) begin
      add(3, 0, 1, bx[i], 137, 4'b0000, 0,     0, 0, 0);
      add(1, 0, 1, bx[i], 137, bh[i],   bi[i], 1, 0, 0);
      add(1, 0, 1, bx[i], 137, bh[i],   bi[i], 0, 0, 0);
      add(2, 0, 0, bx[i], 137, bh[i],   bi[i], 0, 0, 0);
      add(1, 0, 0, bx[i], 137, 4'b0000, 0,     0, 0, 1);
      add(1, 0, 0, bx[i], 137, 4'b0000, 0,     0, 0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // reset in HELD: no release, then a still-high z requalifies from scratch
    for (int i = 0; i < 3; i++) applyStimulus(mk(0, 1, 360, 300, 4'b0000, 0, 0, 0, 0));
    applyStimulus(mk(0, 1, 360, 300, 4'b1000, 3, 1, 0, 0));
    for (int i = 0; i < 2; i++) applyStimulus(mk(0, 1, 360, 300, 4'b1000, 3, 0, 0, 0));
    applyStimulus(mk(1, 1, 360, 300, 4'b0000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) applyStimulus(mk(0, 1, 360, 300, 4'b0000, 0, 0, 0, 0));
    applyStimulus(mk(0, 1, 360, 300, 4'b1000, 3, 1, 0, 0));
    for (int i = 0; i < 2; i++) applyStimulus(mk(0, 0, 360, 300, 4'b1000, 3, 0, 0, 0));
    applyStimulus(mk(0, 0, 360, 300, 4'b0000, 0, 0, 0, 1));
    applyStimulus(mk(0, 0, 360, 300, 4'b0000, 0, 0, 0, 0));

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/touch_zones.md
TOUCH_ZONES -- requirements
Module: touch_zones

Interface
REQ-001 The block SHALL have parameter N_ZONES, default 3, giving the number of equal-width horizontal touch zones (1..16).
REQ-002 The block SHALL have parameter ZONE_W, default 160, giving the zone width in x units.
REQ-003 The block SHALL have parameter Y_MIN, default 136; a touch is in the button strip only when y > Y_MIN.
REQ-004 The block SHALL have parameter START_CNT, default 10000000, giving the consecutive z-high cycles needed to qualify a press (>=1).
REQ-005 The block SHALL have parameter END_CNT, default 10000000, giving the consecutive z-low cycles needed to qualify a release (>=1).
REQ-006 The block SHALL have parameter LONG_CNT, default 50000000, giving the held cycles after press qualification before a long-press event (>=1).
REQ-007 The block SHALL have parameter CW, default 32, giving the counter width; it must hold max(START_CNT, END_CNT, LONG_CNT).
REQ-008 Port cclk, input, 1: the single clock; all logic is on its rising edge.
REQ-009 Port rst, input, 1: synchronous, active-high reset.
REQ-010 Port z, input, 1: raw touch-present indication.
REQ-011 Port x, input, 12: touch x coordinate.
REQ-012 Port y, input, 12: touch y coordinate.
REQ-013 Port zone_hold, output, N_ZONES: one-hot level for the qualified held zone; all zero when none is held.
REQ-014 Port zone_idx, output, 4: index of the latched zone, valid while any zone_hold bit is set.
REQ-015 Port press, output, 1: one-cycle pulse on press qualification inside a zone.
REQ-016 Port long_press, output, 1: one-cycle pulse once per held touch when LONG_CNT is reached.
REQ-017 Port release, output, 1: one-cycle pulse on release qualification of an in-zone touch.
REQ-018 All outputs SHALL be registered.

Function
REQ-019 The FSM SHALL have states IDLE, QUAL, HELD and RELQ, with one shared counter cnt and one saturating hold counter hcnt.
REQ-020 In IDLE, z=1 SHALL move to QUAL with cnt=1; z=0 stays in IDLE.
REQ-021 In QUAL, z=0 SHALL return to IDLE, clear cnt and produce no output (glitch rejection).
REQ-022 In QUAL, z=1 with cnt<START_CNT SHALL increment cnt.
REQ-023 In QUAL, z=1 with cnt==START_CNT SHALL sample x,y; zone k = the k for which k*ZONE_W <= x < (k+1)*ZONE_W, found by comparison (no divider); the FSM then moves to HELD with hcnt=0.
REQ-024 If y > Y_MIN and x < N_ZONES*ZONE_W on that sample, the block SHALL latch k, set zone_hold[k], set zone_idx=k and pulse press in the same registered update; otherwise the touch SHALL be held invalid with all outputs low until release.
REQ-025 The latched zone SHALL NOT change while in HELD or RELQ, whatever x,y do.
REQ-026 In HELD with z=1, hcnt SHALL increment, saturating at LONG_CNT; long_press SHALL pulse on the cycle hcnt becomes LONG_CNT, only for a valid touch.
REQ-027 In HELD, z=0 SHALL move to RELQ with cnt=1.
REQ-028 In RELQ, z=1 SHALL return to HELD with zone and hcnt preserved (gap bridged, no second press).
REQ-029 In RELQ, z=0 with cnt<END_CNT SHALL increment cnt; at cnt==END_CNT the block SHALL clear zone_hold, pulse release if the touch was valid, and go to IDLE.
REQ-030 press, long_press and release SHALL be mutually exclusive within a cycle and SHALL each be high for exactly one cycle per event.
REQ-031 Boundary values: x == k*ZONE_W SHALL select zone k; y == Y_MIN SHALL count as outside.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, cnt=0, hcnt=0, zone_hold=0, zone_idx=0, press=0, long_press=0, release=0, overriding any other input.
REQ-033 Reset asserted mid-touch SHALL generate no release pulse; after deassertion a still-high z SHALL requalify from cnt=1.

Verification (N_ZONES=4, ZONE_W=120, Y_MIN=136, START_CNT=4, END_CNT=3, LONG_CNT=10)
REQ-034 z high 3 cycles then low -> no press and zone_hold stays 0.
REQ-035 z high with x=240, y=200 -> press pulses and zone_hold=4'b0100 on the 4th high cycle, zone_idx=2.
REQ-036 Hold, then z low 2 cycles, high again -> no release and no second press; zone_hold stays 4'b0100.
REQ-037 Held 10 cycles after press -> single long_press; z low 3 cycles -> single release and zone_hold=0.
REQ-038 x=480 or y=136 at qualification -> no press, long_press or release for the entire touch.
REQ-039 rst pulsed while in HELD -> all outputs 0 on the next cycle with no release; z still high -> press again after 4 cycles.
